load_store_unit: RTL and testbench

//  Initiator side of the byte-addressable data-memory port. Takes one load/store

---
 rtl/load_store_unit_if.sv | 43 ++++
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory strobes between the execute stage,
// the load/store unit and the byte-addressable data memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_size;
  logic [31:0] mem_read_data;

  // LSU side
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_error,
    input  resp_ready,
    output mem_address, mem_write_data, mem_write, mem_read, mem_size,
    input  mem_read_data
  );

  // Execute stage plus memory side
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_error,
    output resp_ready,
    input  mem_address, mem_write_data, mem_write, mem_read, mem_size,
    output mem_read_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: checks alignment/range, strobes memory for
// WAIT_CYCLES+1 cycles, returns extended load data; req_ready only while idle.
module load_store_unit #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned MEM_BYTES   = 8192
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu
);
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [1:0]    size_q;
  logic          write_q, uns_q, first_q, err_q;

  logic [1:0]    size_eff;
  logic [32:0]   nbytes;
  logic          misaligned, out_of_range, req_err;
  logic          accept, access_done;

  // 33-bit sum so an address near 2^32 cannot wrap back into range
  always_comb begin
    size_eff = (lsu.req_size == 2'b11) ? 2'b10 : lsu.req_size;
    case (size_eff)
      2'b00:   nbytes = 33'd1;
      2'b01:   nbytes = 33'd2;
      default: nbytes = 33'd4;
    endcase
    misaligned   = ((size_eff == 2'b01) && lsu.req_addr[0]) ||
                   ((size_eff == 2'b10) && (lsu.req_addr[1:0] != 2'b00));
    out_of_range = ({1'b0, lsu.req_addr} + nbytes) > 33'(MEM_BYTES);
    req_err      = misaligned || out_of_range;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    access_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu.req_valid) begin
          accept  = 1'b1;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          access_done = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (lsu.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the low bits of the memory word matter; upper bits may be anything
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'b00:   extend = {{24{d[7] & ~uns}}, d[7:0]};
      2'b01:   extend = {{16{d[15] & ~uns}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= lsu.req_write;
        uns_q   <= lsu.req_unsigned;
        first_q <= 1'b1;
        cnt_q   <= CW'(WAIT_CYCLES);
        if (req_err) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          addr_q  <= lsu.req_addr;
          wdata_q <= lsu.req_wdata;
          size_q  <= size_eff;
        end
      end
      if (state_q == ACCESS) begin
        first_q <= 1'b0;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
      if (access_done) begin
        rdata_q <= write_q ? 32'd0 : extend(lsu.mem_read_data, size_q, uns_q);
        err_q   <= 1'b0;
      end
    end
  end

  // Strobes decode straight from state so an async reset drops them at once
  assign lsu.req_ready      = (state_q == IDLE);
  assign lsu.resp_valid     = (state_q == RESP);
  assign lsu.resp_rdata     = rdata_q;
  assign lsu.resp_error     = err_q;
  assign lsu.mem_address    = addr_q;
  assign lsu.mem_write_data = wdata_q;
  assign lsu.mem_size       = size_q;
  assign lsu.mem_read       = (state_q == ACCESS) && !write_q;
  assign lsu.mem_write      = (state_q == ACCESS) && write_q && first_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (WAIT_CYCLES 0 and 3) share one memory image;
// a scoreboard queue of model responses is drained by a negedge monitor.
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  load_store_unit_if u_if0 ();
  load_store_unit_if u_if1 ();

  load_store_unit #(.WAIT_CYCLES(0), .MEM_BYTES(8192)) dut0 (
    .clk(clk), .rst_n(rst_n), .lsu(u_if0.slave));
  load_store_unit #(.WAIT_CYCLES(3), .MEM_BYTES(8192)) dut3 (
    .clk(clk), .rst_n(rst_n), .lsu(u_if1.slave));

  assign u_if0.req_valid    = req_valid && !sel;
  assign u_if1.req_valid    = req_valid && sel;
  assign u_if0.req_write    = req_write;
  assign u_if1.req_write    = req_write;
  assign u_if0.req_size     = req_size;
  assign u_if1.req_size     = req_size;
  assign u_if0.req_unsigned = req_unsigned;
  assign u_if1.req_unsigned = req_unsigned;
  assign u_if0.req_addr     = req_addr;
  assign u_if1.req_addr     = req_addr;
  assign u_if0.req_wdata    = req_wdata;
  assign u_if1.req_wdata    = req_wdata;
  assign u_if0.resp_ready   = resp_ready;
  assign u_if1.resp_ready   = resp_ready;

  logic        m_req_ready, m_resp_valid, m_resp_error, m_mem_read, m_mem_write;
  logic [31:0] m_resp_rdata;
  assign m_req_ready  = sel ? u_if1.req_ready  : u_if0.req_ready;
  assign m_resp_valid = sel ? u_if1.resp_valid : u_if0.resp_valid;
  assign m_resp_error = sel ? u_if1.resp_error : u_if0.resp_error;
  assign m_resp_rdata = sel ? u_if1.resp_rdata : u_if0.resp_rdata;
  assign m_mem_read   = sel ? u_if1.mem_read   : u_if0.mem_read;
  assign m_mem_write  = sel ? u_if1.mem_write  : u_if0.mem_write;

  function automatic logic [7:0] fill(input int i);
    return 8'((i * 73 + 29) ^ (i >> 3));
  endfunction

  // Memory seen by the DUTs: returns four bytes from the address, so upper bits are junk
  logic [7:0]  mem [0:8191];
  logic        mem_init = 1'b0;
  logic [12:0] a0, a1;
  assign a0 = u_if0.mem_address[12:0];
  assign a1 = u_if1.mem_address[12:0];
  assign u_if0.mem_read_data = {mem[a0 + 13'd3], mem[a0 + 13'd2], mem[a0 + 13'd1], mem[a0]};
  assign u_if1.mem_read_data = {mem[a1 + 13'd3], mem[a1 + 13'd2], mem[a1 + 13'd1], mem[a1]};

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] = fill(i);
      mem_init = 1'b1;
    end
    if (u_if0.mem_write)
      for (int k = 0; k < (u_if0.mem_size == 2'b00 ? 1 : u_if0.mem_size == 2'b01 ? 2 : 4); k++)
        mem[a0 + 13'(k)] = u_if0.mem_write_data[8*k +: 8];
    if (u_if1.mem_write)
      for (int k = 0; k < (u_if1.mem_size == 2'b00 ? 1 : u_if1.mem_size == 2'b01 ? 2 : 4); k++)
        mem[a1 + 13'(k)] = u_if1.mem_write_data[8*k +: 8];
  end

  // Reference model state
  logic [7:0] ref_mem [0:8191];
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rds;
    int          wrs;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts strobe cycles and response latency, pops on each response handshake
  int   lat, rd_cnt, wr_cnt;
  logic busy = 1'b0, lat_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy     = 1'b0;
      lat_done = 1'b0;
    end else begin
      if (busy) begin
        rd_cnt += int'(m_mem_read);
        wr_cnt += int'(m_mem_write);
        if (!lat_done) begin
          lat++;
          if (m_resp_valid) lat_done = 1'b1;
        end
      end
      if (req_valid && m_req_ready) begin
        busy = 1'b1; lat = 0; lat_done = 1'b0; rd_cnt = 0; wr_cnt = 0;
      end
      if (m_resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_rdata", 64'(m_resp_rdata), 64'(e.rdata));
          check("resp_error", 64'(m_resp_error), 64'(e.err));
          check("resp_latency", 64'(lat), 64'(e.lat));
          check("mem_read_cycles", 64'(rd_cnt), 64'(e.rds));
          check("mem_write_cycles", 64'(wr_cnt), 64'(e.wrs));
        end
        busy = 1'b0;
      end
    end
  end

  // Expected response from byte-level memory arithmetic
  task automatic model(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    int     n, w;
    longint v;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    w = sel ? 3 : 0;
    e.err = ((addr % n) != 0) || (longint'(addr) + n > 8192);
    e.rdata = 32'd0;
    if (!e.err && wr) begin
      for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
    end else if (!e.err) begin
      v = 0;
      for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[int'(addr) + k]);
      if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      e.rdata = 32'(v);
    end
    e.lat = e.err ? 1 : w + 2;
    e.rds = (!e.err && !wr) ? w + 1 : 0;
    e.wrs = (!e.err && wr) ? 1 : 0;
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold);
    exp_t e;
    model(wr, sz, uns, addr, wd, e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && !m_resp_valid; i++) begin
      @(posedge clk); #1;
    end
    if (!m_resp_valid) begin
      check("resp_timeout", 64'd0, 64'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        if (exp_q.size() > 0)
          check("resp_hold", {m_resp_valid, m_resp_rdata, m_resp_error, m_req_ready},
                {1'b1, exp_q[0].rdata, exp_q[0].err, 1'b0});
        @(posedge clk); #1;
      end
    end else begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = fill(i);
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #12;
    check("rst_req_ready", {u_if0.req_ready, u_if1.req_ready}, 2'b11);
    check("rst_resp_valid", {u_if0.resp_valid, u_if1.resp_valid}, 2'b00);
    check("rst_strobes", {u_if0.mem_read, u_if0.mem_write, u_if1.mem_read, u_if1.mem_write}, 4'b0);
    check("rst_mem_address", {u_if0.mem_address, u_if1.mem_address}, 64'd0);
    check("rst_mem_wdata", {u_if0.mem_write_data, u_if1.mem_write_data}, 64'd0);
    check("rst_mem_size", {u_if0.mem_size, u_if1.mem_size}, 4'b0);
    check("rst_resp", {u_if0.resp_rdata, u_if0.resp_error, u_if1.resp_error}, 34'd0);
    #11 rst_n = 1'b1;

    // WAIT_CYCLES = 0 directed cases
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    run_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0);
    run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0, 0);
    run_req(1'b0, 2'b01, 1'b0, 32'h1FFF, 32'h0, 0);
    run_req(1'b0, 2'b00, 1'b0, 32'h1FFF, 32'h0, 0);
    run_req(1'b0, 2'b11, 1'b1, 32'hFFFF_FFFC, 32'h0, 0);
    run_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h8001_7F80, 0);
    run_req(1'b0, 2'b11, 1'b1, 32'h20, 32'h0, 0);

    // WAIT_CYCLES = 3: stretched access and a stalled response
    sel = 1'b1;
    run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 0);
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5);
    run_req(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 5);

    // Reset in the middle of an access
    @(posedge clk); #1;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    check("mid_access_read", 64'(m_mem_read), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_strobes", {m_mem_read, m_mem_write, m_resp_valid}, 3'b000);
    #10 rst_n = 1'b1;
    #1;
    check("post_reset_ready", 64'(m_req_ready), 64'd1);
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 30; i++) begin
        logic [31:0] addr;
        case ($urandom_range(0, 3))
          0:       addr = $urandom_range(0, 63);
          1:       addr = $urandom_range(8180, 8199);
          2:       addr = $urandom;
          default: addr = $urandom_range(0, 8191);
        endcase
        run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                addr, $urandom, 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
